// File: rtl/esram_rd_client.sv
// esram_rd_fifo: single-clock FIFO with a first-word-fall-through head.
// Latency: a pushed entry is visible at the head one cycle after the write edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module esram_rd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk_esram,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk_esram) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk_esram) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// esram_rd_client: turns (addr, len) read requests into eSRAM rden pulses and a sop/eop flit stream.
// Latency: request handshake to first out_valid is RD_LAT+2 cycles.
// Backpressure: reads are issued only against free output-FIFO credits; the eSRAM return is never stalled.
module esram_rd_client #(
  parameter int RD_LAT     = 12,
  parameter int FIFO_DEPTH = 32,
  parameter int AWIDTH     = 17,
  parameter int DWIDTH     = 520,
  parameter int LEN_W      = 6
) (
  input  logic              clk_esram,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              esram_rden,
  output logic [AWIDTH-1:0] esram_rdaddress,
  input  logic              esram_rd_valid,
  input  logic [DWIDTH-1:0] esram_rddata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              err_overflow,
  output logic              err_spurious
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DCW = $clog2(RD_LAT + 1);
  localparam logic [CW:0]     DEPTH_V  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [DCW-1:0]  DRAIN_V  = DCW'(RD_LAT);

  typedef enum logic [1:0] {DRAIN, IDLE, ISSUE} state_t;

  typedef struct packed {
    logic sop;
    logic eop;
  } tag_t;

  state_t            state, state_nxt;
  logic [DCW-1:0]    drain_cnt, drain_cnt_nxt;
  logic [AWIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic              first, first_nxt;
  logic              issue;

  logic [CW-1:0]     inflight;
  logic [CW-1:0]     data_cnt;
  logic [CW:0]       used;
  logic              has_credit;

  logic              ret;
  logic              ret_ok;
  logic              data_pop;
  logic              data_full;
  tag_t              tag_in;
  tag_t              tag_head;
  logic [CW-1:0]     tag_cnt;
  logic              unused_tag_cnt;

  // Reads in flight plus flits already buffered must never exceed the FIFO depth.
  assign used       = {1'b0, inflight} + {1'b0, data_cnt};
  assign has_credit = used < DEPTH_V;
  assign issue      = (state == ISSUE) && has_credit;
  assign req_ready  = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    first_nxt     = first;
    case (state)
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = IDLE;
        else                 drain_cnt_nxt = drain_cnt - 1'b1;
      end
      IDLE: begin
        if (req_valid && (req_len != '0)) begin
          cur_addr_nxt  = req_addr;
          remaining_nxt = req_len;
          first_nxt     = 1'b1;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          cur_addr_nxt  = cur_addr + 1'b1;
          remaining_nxt = remaining - 1'b1;
          first_nxt     = 1'b0;
          if (remaining == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = DRAIN;
    endcase
  end

  // Returns during DRAIN belong to reads issued before reset and are discarded silently.
  assign ret       = esram_rd_valid && (state != DRAIN);
  assign ret_ok    = ret && (inflight != '0);
  assign data_pop  = out_valid && out_ready;
  assign data_full = (data_cnt == FULL_CNT);

  always_ff @(posedge clk_esram) begin
    if (rst) begin
      state           <= DRAIN;
      drain_cnt       <= DRAIN_V;
      cur_addr        <= '0;
      remaining       <= '0;
      first           <= 1'b0;
      esram_rden      <= 1'b0;
      esram_rdaddress <= '0;
      inflight        <= '0;
      err_overflow    <= 1'b0;
      err_spurious    <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= drain_cnt_nxt;
      cur_addr   <= cur_addr_nxt;
      remaining  <= remaining_nxt;
      first      <= first_nxt;
      esram_rden <= issue;
      if (issue) esram_rdaddress <= cur_addr;
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      if (ret_ok && data_full && !data_pop) err_overflow <= 1'b1;
      if (ret && (inflight == '0))          err_spurious <= 1'b1;
    end
  end

  esram_rd_fifo #(
    .W     (DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk_esram (clk_esram),
    .rst       (rst),
    .push      (ret_ok),
    .push_dat  (esram_rddata),
    .pop       (data_pop),
    .head      (out_data),
    .count     (data_cnt)
  );

  assign tag_in.sop = first;
  assign tag_in.eop = (remaining == LEN_W'(1));

  // Tags are queued at issue time and pop in lockstep with the data head.
  esram_rd_fifo #(
    .W     ($bits(tag_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_esram (clk_esram),
    .rst       (rst),
    .push      (issue),
    .push_dat  (tag_in),
    .pop       (data_pop),
    .head      (tag_head),
    .count     (tag_cnt)
  );

  assign unused_tag_cnt = ^tag_cnt;

  assign out_valid = (data_cnt != '0);
  assign out_sop   = out_valid && tag_head.sop;
  assign out_eop   = out_valid && tag_head.eop;
endmodule

// File: tb/tb_esram_rd_client.sv
module tb_esram_rd_client;
  localparam int RD_LAT     = 12;
  localparam int FIFO_DEPTH = 32;
  localparam int AWIDTH     = 17;
  localparam int DWIDTH     = 520;
  localparam int LEN_W      = 6;

  logic              clk_esram = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AWIDTH-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              esram_rden;
  logic [AWIDTH-1:0] esram_rdaddress;
  logic              esram_rd_valid;
  logic [DWIDTH-1:0] esram_rddata;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DWIDTH-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              err_overflow;
  logic              err_spurious;

  always #5 clk_esram = ~clk_esram;

  esram_rd_client #(
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .LEN_W(LEN_W)
  ) dut (
    .clk_esram(clk_esram), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .esram_rden(esram_rden), .esram_rdaddress(esram_rdaddress),
    .esram_rd_valid(esram_rd_valid), .esram_rddata(esram_rddata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  // eSRAM model: fixed-latency return, content is a pure function of the address.
  function automatic logic [DWIDTH-1:0] mem_word(input logic [AWIDTH-1:0] a);
    return {26{3'b101, a}};
  endfunction

  logic [RD_LAT-1:0] pv = '0;
  logic [AWIDTH-1:0] pa [RD_LAT];
  logic              inj = 1'b0;

  always @(posedge clk_esram) begin
    pv    <= {pv[RD_LAT-2:0], esram_rden};
    pa[0] <= esram_rdaddress;
    for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
  end

  assign esram_rd_valid = pv[RD_LAT-1] | inj;
  assign esram_rddata   = mem_word(pa[RD_LAT-1]);

  int cyc = 0;
  always @(posedge clk_esram) cyc <= cyc + 1;

  typedef struct packed {
    logic [DWIDTH-1:0] d;
    logic              sop;
    logic              eop;
  } flit_t;

  typedef struct {
    logic [AWIDTH-1:0] addr;
    logic [LEN_W-1:0]  len;
    int                exp_rd;
    int                exp_out;
    int                rd_lat;
    int                out_lat;
    int                span;
    logic [AWIDTH-1:0] last_addr;
  } vec_t;

  logic [AWIDTH-1:0] exp_addr[$];
  flit_t             exp_flit[$];
  int                rden_cyc[$];
  logic [AWIDTH-1:0] rden_addr[$];
  int                out_cyc[$];
  int                a_idx = 0, f_idx = 0, outstanding = 0, max_out = 0;
  bit                done = 1'b0, rand_rdy = 1'b0;
  int                checks = 0, failures = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_esram);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(req_ready == 1'b0,      {tag, "_req_ready"},  req_ready, 0);
    chk(esram_rden == 1'b0,     {tag, "_rden"},       esram_rden, 0);
    chk(esram_rdaddress == '0,  {tag, "_rdaddress"},  esram_rdaddress, 0);
    chk(out_valid == 1'b0,      {tag, "_out_valid"},  out_valid, 0);
    chk(out_sop == 1'b0,        {tag, "_out_sop"},    out_sop, 0);
    chk(out_eop == 1'b0,        {tag, "_out_eop"},    out_eop, 0);
    chk(err_overflow == 1'b0,   {tag, "_err_ovf"},    err_overflow, 0);
    chk(err_spurious == 1'b0,   {tag, "_err_spur"},   err_spurious, 0);
  endtask

  task automatic drain_wait(input string tag);
    int n = 0;
    bit rdy = 1'b0, anyv = 1'b0;
    while (!rdy && n < 40) begin
      @(negedge clk_esram);
      anyv |= out_valid;
      if (req_ready) rdy = 1'b1;
      else n++;
    end
    chk(n == RD_LAT + 1, {tag, "_drain_cycles"}, n, RD_LAT + 1);
    chk(!anyv, {tag, "_drain_no_valid"}, anyv, 0);
  endtask

  task automatic send_req(input logic [AWIDTH-1:0] a, input logic [LEN_W-1:0] l,
                          output int hs, output int waits);
    bit ok = 1'b0;
    logic [AWIDTH-1:0] ad;
    waits = 0;
    req_addr = a; req_len = l; req_valid = 1'b1;
    while (!ok && waits < 500) begin
      @(negedge clk_esram);
      if (req_ready) ok = 1'b1;
      else waits++;
      @(posedge clk_esram);
      #1;
    end
    req_valid = 1'b0;
    hs = cyc;
    chk(ok, "req_handshake", waits, 0);
    if (ok) begin
      for (int i = 0; i < int'(l); i++) begin
        ad = a + AWIDTH'(i);
        exp_addr.push_back(ad);
        exp_flit.push_back('{mem_word(ad), i == 0, i == int'(l) - 1});
      end
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int n = 0;
    while (out_cyc.size() < target && n < budget) begin
      @(negedge clk_esram);
      n++;
    end
    chk(out_cyc.size() >= target, name, out_cyc.size(), target);
  endtask

  task automatic monitor_loop();
    flit_t ef;
    while (!done) begin
      @(negedge clk_esram);
      if (rst) begin
        a_idx = exp_addr.size();
        f_idx = exp_flit.size();
        outstanding = 0;
      end else begin
        if (esram_rden) begin
          rden_cyc.push_back(cyc);
          rden_addr.push_back(esram_rdaddress);
          outstanding++;
          if (outstanding > max_out) max_out = outstanding;
          chk(a_idx < exp_addr.size(), "rden_expected", a_idx, exp_addr.size());
          if (a_idx < exp_addr.size()) begin
            chk(esram_rdaddress == exp_addr[a_idx], "rdaddress", esram_rdaddress, exp_addr[a_idx]);
            a_idx++;
          end
        end
        if (out_valid && out_ready) begin
          out_cyc.push_back(cyc);
          outstanding--;
          chk(f_idx < exp_flit.size(), "flit_expected", f_idx, exp_flit.size());
          if (f_idx < exp_flit.size()) begin
            ef = exp_flit[f_idx];
            f_idx++;
            chk(out_data == ef.d, "out_data", out_data[63:0], ef.d[63:0]);
            chk({out_sop, out_eop} == {ef.sop, ef.eop}, "sop_eop", {out_sop, out_eop}, {ef.sop, ef.eop});
          end
        end
      end
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic main_seq();
    vec_t vecs[4];
    int e, w, rb, ob, n, tgt;
    logic [AWIDTH-1:0] ra;
    logic [LEN_W-1:0]  rl;

    vecs[0] = '{17'h00100, 6'd4, 4, 4, 1, 14, 3, 17'h00103};
    vecs[1] = '{17'h1FFFE, 6'd4, 4, 4, 1, 14, 3, 17'h00001};
    vecs[2] = '{17'h00055, 6'd0, 0, 0, 0, 0,  0, 17'h00000};
    vecs[3] = '{17'h00077, 6'd1, 1, 1, 1, 14, 0, 17'h00077};

    repeat (3) @(posedge clk_esram);
    @(negedge clk_esram);
    check_reset_outputs("por");
    tick();
    rst = 1'b0;
    drain_wait("por");

    for (int i = 0; i < 4; i++) begin
      tick();
      rb = rden_cyc.size();
      ob = out_cyc.size();
      send_req(vecs[i].addr, vecs[i].len, e, w);
      chk(w == 0, "hs_wait", w, 0);
      if (vecs[i].exp_out > 0) wait_pops(ob + vecs[i].exp_out, 100, "vec_flits_arrive");
      else repeat (20) @(negedge clk_esram);
      repeat (4) @(negedge clk_esram);
      chk(rden_cyc.size() - rb == vecs[i].exp_rd, "vec_rden_count", rden_cyc.size() - rb, vecs[i].exp_rd);
      chk(out_cyc.size() - ob == vecs[i].exp_out, "vec_flit_count", out_cyc.size() - ob, vecs[i].exp_out);
      if (vecs[i].exp_rd > 0 && rden_cyc.size() >= rb + vecs[i].exp_rd) begin
        chk(rden_cyc[rb] - e == vecs[i].rd_lat, "vec_rden_latency", rden_cyc[rb] - e, vecs[i].rd_lat);
        chk(rden_addr[rb + vecs[i].exp_rd - 1] == vecs[i].last_addr, "vec_last_addr",
            rden_addr[rb + vecs[i].exp_rd - 1], vecs[i].last_addr);
      end
      if (vecs[i].exp_out > 0 && out_cyc.size() >= ob + vecs[i].exp_out) begin
        chk(out_cyc[ob] - e == vecs[i].out_lat, "vec_out_latency", out_cyc[ob] - e, vecs[i].out_lat);
        chk(out_cyc[ob + vecs[i].exp_out - 1] - out_cyc[ob] == vecs[i].span, "vec_out_span",
            out_cyc[ob + vecs[i].exp_out - 1] - out_cyc[ob], vecs[i].span);
      end
    end

    // Credit limit with a stalled consumer.
    tick();
    out_ready = 1'b0;
    rb = rden_cyc.size();
    ob = out_cyc.size();
    send_req(17'h00200, 6'd40, e, w);
    repeat (60) @(negedge clk_esram);
    chk(rden_cyc.size() - rb == FIFO_DEPTH, "stall_rden_count", rden_cyc.size() - rb, FIFO_DEPTH);
    chk(out_valid == 1'b1, "stall_out_valid", out_valid, 1);
    chk(req_ready == 1'b0, "stall_still_issuing", req_ready, 0);
    tick();
    out_ready = 1'b1;
    wait_pops(ob + 40, 200, "stall_release_flits");
    repeat (4) @(negedge clk_esram);
    chk(rden_cyc.size() - rb == 40, "stall_total_rden", rden_cyc.size() - rb, 40);
    chk(err_overflow == 1'b0, "stall_no_overflow", err_overflow, 0);

    // Random requests against a randomly throttled consumer.
    tick();
    rand_rdy = 1'b1;
    tgt = out_cyc.size();
    for (int k = 0; k < 25; k++) begin
      ra = AWIDTH'($urandom_range(0, (1 << AWIDTH) - 1));
      rl = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      send_req(ra, rl, e, w);
      tgt += int'(rl);
    end
    wait_pops(tgt, 6000, "random_flits");
    tick();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk_esram);
    chk(max_out <= FIFO_DEPTH, "random_max_outstanding", max_out, FIFO_DEPTH);
    chk(err_overflow == 1'b0, "random_no_overflow", err_overflow, 0);
    chk(err_spurious == 1'b0, "random_no_spurious", err_spurious, 0);
    chk(out_valid == 1'b0, "random_drained", out_valid, 0);

    // Reset in the middle of an issue burst with six reads in flight.
    tick();
    send_req(17'h00300, 6'd20, e, w);
    n = 0;
    for (int g = 0; g < 40 && n < 6; g++) begin
      @(negedge clk_esram);
      if (esram_rden) n++;
    end
    chk(n == 6, "midrst_six_inflight", n, 6);
    rst = 1'b1;
    @(negedge clk_esram);
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    drain_wait("midrst");
    chk(err_overflow == 1'b0, "midrst_no_overflow", err_overflow, 0);
    chk(err_spurious == 1'b0, "midrst_no_spurious", err_spurious, 0);
    tick();
    ob = out_cyc.size();
    send_req(17'h00400, 6'd2, e, w);
    wait_pops(ob + 2, 100, "postrst_flits");
    repeat (4) @(negedge clk_esram);
    chk(out_cyc.size() - ob == 2, "postrst_flit_count", out_cyc.size() - ob, 2);

    // Spurious return with nothing in flight.
    repeat (20) @(negedge clk_esram);
    chk(err_spurious == 1'b0, "spur_before", err_spurious, 0);
    tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk_esram);
    chk(err_spurious == 1'b1, "spur_set", err_spurious, 1);
    chk(out_valid == 1'b0, "spur_no_valid", out_valid, 0);
    repeat (5) @(negedge clk_esram);
    chk(err_spurious == 1'b1, "spur_sticky", err_spurious, 1);
    chk(out_valid == 1'b0, "spur_still_no_valid", out_valid, 0);
    chk(err_overflow == 1'b0, "spur_no_overflow", err_overflow, 0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor_loop();
      main_seq();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
